// File: rtl/idu_wb_regfile_if.sv
// Writeback-to-decode handshake bundle: valid/ready plus packed {data, addr, regW} bus.
// The writeback stage drives it as master; the decode-side register file is the slave.
interface idu_wb_regfile_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
);
    logic                                wb_to_id_valid;
    logic                                id_to_wb_ready;
    logic [DATA_WIDTH+REG_ADDR_WIDTH:0]  wb_to_id_bus;

    modport master (output wb_to_id_valid, output wb_to_id_bus, input  id_to_wb_ready);
    modport slave  (input  wb_to_id_valid, input  wb_to_id_bus, output id_to_wb_ready);
endinterface

// File: rtl/idu_wb_regfile.sv
// Decode-side register file with writeback handshake, per-register pending-write scoreboard
// and two combinational read ports. Define RF_BYPASS_EN for same-cycle writeback bypass.
module idu_wb_regfile #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    idu_wb_regfile_if.slave           wb,
    input  logic                      issue_valid,
    input  logic                      issue_regW,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic                      rs1_busy,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      rs2_busy,
    output logic                      wb_err
);
    localparam int                   NREG    = 1 << REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;
    } rd_t;

    logic [DATA_WIDTH-1:0]     rf_q  [NREG];
    logic [CNT_WIDTH-1:0]      cnt_q [NREG];
    logic [CNT_WIDTH-1:0]      cnt_d [NREG];
    logic                      ready_q;
    logic                      wb_err_q, wb_err_d;

    logic                      wb_regw;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      wb_fire, rel, res, same_reg;
    rd_t                       rd1, rd2;

    assign wb_regw = wb.wb_to_id_bus[0];
    assign wb_addr = wb.wb_to_id_bus[REG_ADDR_WIDTH:1];
    assign wb_data = wb.wb_to_id_bus[DATA_WIDTH+REG_ADDR_WIDTH:REG_ADDR_WIDTH+1];

    assign wb.id_to_wb_ready = ready_q;
    assign wb_fire  = wb.wb_to_id_valid && ready_q;
    assign rel      = wb_fire && wb_regw && (wb_addr != '0);
    assign same_reg = (wb_addr == issue_rd);

    // A release landing on the same register frees a slot, so a full counter may still accept.
    assign issue_ready = !(issue_regW && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX)
                           && !(rel && same_reg));
    assign res = issue_valid && issue_ready && issue_regW && (issue_rd != '0);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        wb_err_d = wb_err_q;
        if (res && !(rel && same_reg))
            cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_WIDTH'(1);
        if (rel && !(res && same_reg)) begin
            if (cnt_q[wb_addr] != '0) cnt_d[wb_addr] = cnt_q[wb_addr] - CNT_WIDTH'(1);
            else                      wb_err_d       = 1'b1;
        end
    end

    function automatic rd_t read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
        rd_t r;
        r.data = rf_q[addr];
        r.busy = (cnt_q[addr] != '0);
`ifdef RF_BYPASS_EN
        if (rel && (addr == wb_addr)) begin
            r.data = wb_data;
            r.busy = (cnt_q[addr] > CNT_WIDTH'(1));
        end
`endif
        if (addr == '0) begin
            r.data = '0;
            r.busy = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(rs1_addr);
        rd2 = read_port(rs2_addr);
    end

    assign rs1_data = rd1.data;
    assign rs1_busy = rd1.busy;
    assign rs2_data = rd2.data;
    assign rs2_busy = rd2.busy;
    assign wb_err   = wb_err_q;

    // NOTE: state uses non-blocking assignments; the register array is cleared on reset
    // because architectural registers must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            wb_err_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            ready_q  <= 1'b1;
            wb_err_q <= wb_err_d;
            cnt_q    <= cnt_d;
            if (rel) rf_q[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_idu_wb_regfile.sv
// Self-checking bench for idu_wb_regfile: directed scenarios plus randomized traffic
// against an array-based reference model of the register file and scoreboard.
module tb_idu_wb_regfile;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int NREG = 1 << AW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst;
    logic          issue_valid, issue_regW, issue_ready;
    logic [AW-1:0] issue_rd, rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          rs1_busy, rs2_busy, wb_err;

    idu_wb_regfile_if #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

    idu_wb_regfile #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .wb(wb_if),
        .issue_valid(issue_valid), .issue_regW(issue_regW), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_rf  [NREG];
    int            m_cnt [NREG];
    bit            m_err;
    bit            m_ready;

    function automatic logic [DW+AW:0] bus(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                           input logic w);
        return {d, a, w};
    endfunction

    function automatic logic [AW-1:0] m_waddr();
        return wb_if.wb_to_id_bus[AW:1];
    endfunction

    function automatic bit m_rel();
        return wb_if.wb_to_id_valid && m_ready && wb_if.wb_to_id_bus[0] && (m_waddr() != 0);
    endfunction

    function automatic bit m_issue_ready();
        if (issue_regW && issue_rd != 0 && m_cnt[issue_rd] == CMAX
            && !(m_rel() && m_waddr() == issue_rd)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                   output logic b);
        d = m_rf[a];
        b = m_cnt[a] != 0;
`ifdef RF_BYPASS_EN
        if (m_rel() && a == m_waddr()) begin
            d = wb_if.wb_to_id_bus[DW+AW:AW+1];
            b = m_cnt[a] > 1;
        end
`endif
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    // Advance one clock, applying the architectural rules to the model, then settle 1 time unit.
    task automatic tick();
        bit rel, res;
        logic [AW-1:0] ra, wa;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_rf[i]  = '0;
                m_cnt[i] = 0;
            end
            m_err   = 1'b0;
            m_ready = 1'b0;
        end else begin
            rel = m_rel();
            res = issue_valid && m_issue_ready() && issue_regW && issue_rd != 0;
            ra  = issue_rd;
            wa  = m_waddr();
            if (rel) m_rf[wa] = wb_if.wb_to_id_bus[DW+AW:AW+1];
            if (!(res && rel && ra == wa)) begin
                if (res) m_cnt[ra]++;
                if (rel) begin
                    if (m_cnt[wa] > 0) m_cnt[wa]--;
                    else               m_err = 1'b1;
                end
            end
            m_ready = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_regW = 0; issue_rd = '0;
        wb_if.wb_to_id_valid = 0; wb_if.wb_to_id_bus = '0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        rst = 0;
        idle_inputs();
        rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (wb_if.id_to_wb_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready_low: got %b want 0", wb_if.id_to_wb_ready);
            end
        end
        rst = 1;
        #1;
        n_tests++;
        if (wb_if.id_to_wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge: got %b want 0", wb_if.id_to_wb_ready);
        end
        tick();
        n_tests++;
        if (wb_if.id_to_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_release: got %b want 1", wb_if.id_to_wb_ready);
        end
        for (int i = 0; i < 4; i++) begin
            a = AW'($urandom_range(0, NREG - 1));
            rs1_addr = a;
            #1;
            n_tests++;
            if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_read x%0d: got %h/%b want 0/0", a, rs1_data, rs1_busy);
            end
        end
        n_tests++;
        if (wb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", wb_err);
        end
    endtask

    task automatic test_reserve_writeback();
        issue_valid = 1; issue_regW = 1; issue_rd = 5;
        tick();
        idle_inputs();
        rs1_addr = 5;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL reserve_busy: got %b want 1", rs1_busy);
        end
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'hDEADBEEF, 5, 1);
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rs1_data !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL writeback_x5: got %h/%b want deadbeef/0", rs1_data, rs1_busy);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old;
        issue_valid = 1; issue_regW = 1; issue_rd = 7;
        tick();
        idle_inputs();
        old = 32'h0;
        rs2_addr = 7;
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'h1234, 7, 1);
        #1;
        n_tests++;
`ifdef RF_BYPASS_EN
        if (rs2_data !== 32'h1234 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h/%b want 1234/0", rs2_data, rs2_busy);
        end
`else
        if (rs2_data !== old || rs2_busy !== 1'b1) begin
            n_fail++; $display("FAIL nobypass_same_cycle: got %h/%b want %h/1", rs2_data, rs2_busy, old);
        end
`endif
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rs2_data !== 32'h1234 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass_next_cycle: got %h/%b want 1234/0", rs2_data, rs2_busy);
        end
    endtask

    task automatic test_saturation();
        issue_valid = 1; issue_regW = 1; issue_rd = 3;
        for (int i = 0; i < CMAX; i++) begin
            #1;
            n_tests++;
            if (issue_ready !== 1'b1) begin
                n_fail++; $display("FAIL sat_fill_%0d: got %b want 1", i, issue_ready);
            end
            tick();
        end
        #1;
        n_tests++;
        if (issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL sat_full: got %b want 0", issue_ready);
        end
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'h3333, 3, 1);
        #1;
        n_tests++;
        if (issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL sat_release_frees: got %b want 1", issue_ready);
        end
        tick();
        wb_if.wb_to_id_valid = 0;
        rs1_addr = 3;
        #1;
        n_tests++;
        if (issue_ready !== 1'b0 || rs1_busy !== 1'b1 || wb_err !== 1'b0) begin
            n_fail++; $display("FAIL sat_still_full: got ready=%b busy=%b err=%b want 0/1/0",
                               issue_ready, rs1_busy, wb_err);
        end
        idle_inputs();
        for (int i = 0; i < CMAX; i++) begin
            wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(DW'(32'h300 + i), 3, 1);
            tick();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'h302 || wb_err !== 1'b0) begin
            n_fail++; $display("FAIL sat_drained: got %h/%b err=%b want 302/0/0", rs1_data, rs1_busy, wb_err);
        end
    endtask

    task automatic test_x0_regw0();
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'hFFFFFFFF, 0, 1);
        tick();
        wb_if.wb_to_id_bus = bus(32'hAA, 4, 0);
        tick();
        idle_inputs();
        rs1_addr = 0; rs2_addr = 4;
        #1;
        n_tests++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL x0_read: got %h/%b want 0/0", rs1_data, rs1_busy);
        end
        n_tests++;
        if (rs2_data !== '0 || rs2_busy !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++; $display("FAIL regw0_x4: got %h/%b err=%b want 0/0/0", rs2_data, rs2_busy, wb_err);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d1, d2;
        logic          b1, b2;
        logic [AW-1:0] wa;
        for (int c = 0; c < 400; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_regW  = ($urandom_range(0, 3) != 0);
            issue_rd    = AW'($urandom_range(0, 7));
            wa          = AW'($urandom_range(0, 7));
            wb_if.wb_to_id_valid = 1'($urandom_range(0, 1));
            if (m_cnt[wa] == 0 && $urandom_range(0, 7) != 0) wb_if.wb_to_id_valid = 0;
            wb_if.wb_to_id_bus = bus(DW'($urandom), wa, ($urandom_range(0, 5) != 0));
            rs1_addr = AW'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            #1;
            m_read(rs1_addr, d1, b1);
            m_read(rs2_addr, d2, b2);
            n_tests++;
            if (issue_ready !== m_issue_ready()) begin
                n_fail++; $display("FAIL rand_issue_ready c%0d: got %b want %b", c, issue_ready, m_issue_ready());
            end
            n_tests++;
            if (rs1_data !== d1 || rs1_busy !== b1) begin
                n_fail++; $display("FAIL rand_rs1 c%0d x%0d: got %h/%b want %h/%b", c, rs1_addr, rs1_data, rs1_busy, d1, b1);
            end
            n_tests++;
            if (rs2_data !== d2 || rs2_busy !== b2) begin
                n_fail++; $display("FAIL rand_rs2 c%0d x%0d: got %h/%b want %h/%b", c, rs2_addr, rs2_data, rs2_busy, d2, b2);
            end
            n_tests++;
            if (wb_err !== m_err || wb_if.id_to_wb_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand_err_ready c%0d: got %b/%b want %b/1", c, wb_err, wb_if.id_to_wb_ready, m_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_underflow();
        // Drain whatever the random phase left outstanding so x9 is known clear.
        rst = 0;
        tick();
        rst = 1;
        tick();
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'h55, 9, 1);
        tick();
        idle_inputs();
        rs1_addr = 9;
        #1;
        n_tests++;
        if (rs1_data !== 32'h55 || rs1_busy !== 1'b0 || wb_err !== 1'b1) begin
            n_fail++; $display("FAIL underflow: got %h/%b err=%b want 55/0/1", rs1_data, rs1_busy, wb_err);
        end
        issue_valid = 1; issue_regW = 1; issue_rd = 9;
        tick();
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'h66, 9, 1);
        issue_valid = 0;
        tick();
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (wb_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", wb_err);
        end
    endtask

    task automatic test_reset_mid_op();
        issue_valid = 1; issue_regW = 1; issue_rd = 2;
        tick();
        issue_valid = 0;
        wb_if.wb_to_id_valid = 1; wb_if.wb_to_id_bus = bus(32'h77, 2, 1);
        rst = 0;
        tick();
        rst = 1;
        idle_inputs();
        rs1_addr = 2; rs2_addr = 9;
        #1;
        n_tests++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0 || rs2_data !== '0 || wb_err !== 1'b0
            || wb_if.id_to_wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_op: got x2=%h/%b x9=%h err=%b rdy=%b want 0/0/0/0/0",
                               rs1_data, rs1_busy, rs2_data, wb_err, wb_if.id_to_wb_ready);
        end
        tick();
        n_tests++;
        if (wb_if.id_to_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_op_ready: got %b want 1", wb_if.id_to_wb_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_rf[i]  = '0;
            m_cnt[i] = 0;
        end
        m_err = 0; m_ready = 0;
        test_reset();
        test_reserve_writeback();
        test_bypass();
        test_saturation();
        test_x0_regw0();
        test_random();
        test_underflow();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/idu_wb_regfile.md
Name: idu_wb_regfile

Overview:
ID-side receiver for the writeback-to-decode interface: the register file plus write-port handshake, sitting at the decode end of the NPC pipeline.
- Accepts the writeback bus {data, addr, regW} via valid/ready and commits it to the architectural registers.
- Keeps a per-register pending-write scoreboard, reserved by decode at issue and released by writeback, so decode detects RAW hazards.
- Provides two combinational read ports with optional same-cycle writeback bypass.

Parameters:
REG_ADDR_WIDTH, 5, register index width; 2^REG_ADDR_WIDTH registers, x0 hardwired zero
DATA_WIDTH, 32, register data width
CNT_WIDTH, 2, per-register pending counter width; max outstanding writes per register = 2^CNT_WIDTH-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
wb_to_id_valid  in  1  writeback bus valid
id_to_wb_ready  out  1  receiver ready
wb_to_id_bus  in  DATA_WIDTH+REG_ADDR_WIDTH+1  bit0 = regW; [REG_ADDR_WIDTH:1] = addr; [DATA_WIDTH+REG_ADDR_WIDTH:REG_ADDR_WIDTH+1] = data
issue_valid  in  1  decode issues an instruction this cycle
issue_regW  in  1  issued instruction writes a register
issue_rd  in  REG_ADDR_WIDTH  destination register of issued instruction
issue_ready  out  1  reservation can be accepted
rs1_addr  in  REG_ADDR_WIDTH  read port 1 index
rs1_data  out  DATA_WIDTH  read port 1 data
rs1_busy  out  1  rs1 has outstanding writes
rs2_addr  in  REG_ADDR_WIDTH  read port 2 index
rs2_data  out  DATA_WIDTH  read port 2 data
rs2_busy  out  1  rs2 has outstanding writes
wb_err  out  1  sticky: writeback to a register with no pending reservation

Behaviour:
- Reset (rst=0 at posedge):
  - All registers = 0; all counters = 0; wb_err = 0.
  - id_to_wb_ready is registered: 0 during reset, 1 from the first posedge with rst=1, then held 1.
- Writeback commit: wb_fire = wb_to_id_valid && id_to_wb_ready.
  - On wb_fire with regW=1 and addr!=0: reg[addr] <= data at the posedge. Visible to plain reads the next cycle.
  - regW=0 or addr=0: bus is consumed, no register write, no counter change.
- Scoreboard:
  - res = issue_valid && issue_ready && issue_regW && issue_rd!=0.
  - rel = wb_fire && regW && addr!=0.
  - res only on register r: cnt[r]++.
  - rel only on r: cnt[r]-- if cnt[r]>0; else cnt stays 0 and wb_err <= 1 (sticky until reset).
  - res and rel on the same r in the same cycle: cnt unchanged; no error even if cnt was 0.
  - res and rel on different registers: both apply independently.
- issue_ready:
  - Combinational.
  - 0 only when issue_regW=1, issue_rd!=0 and cnt[issue_rd] = 2^CNT_WIDTH-1 with no same-cycle rel on issue_rd; otherwise 1.
  - A same-cycle rel on issue_rd frees a slot, so issue_ready=1 even when cnt is at max.
- Read ports (combinational):
  - addr 0 always returns data 0, busy 0.
  - Otherwise data = reg[addr] and busy = (cnt[addr]!=0), unless modified by the optional feature.
  - The same-cycle reservation does not affect busy (it takes effect next cycle).
- Reset mid-operation: an in-flight wb_fire in the reset cycle is dropped; all state is cleared.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: when rel occurs and rsN_addr == addr (nonzero), rsN_data = incoming data in the same cycle, and rsN_busy = (cnt[addr] > 1).
- Undefined: no bypass; the read shows the old value and busy=(cnt!=0) until the posedge after the write.

Test Plan:
- Reset: hold rst=0 two cycles, release -> id_to_wb_ready 0 in the reset cycles, 1 on the first posedge after release; rs1 at any address reads 0, busy 0; wb_err 0.
- Reserve x5 (issue_valid=1, issue_regW=1, issue_rd=5), next cycle rs1_addr=5 -> rs1_busy=1; writeback {data=0xDEADBEEF, addr=5, regW=1} -> the cycle after, rs1_data=0xDEADBEEF and rs1_busy=0.
- Bypass: cnt[7]=1, same cycle writeback {0x1234, 7, 1} with rs2_addr=7 -> RF_BYPASS_EN: rs2_data=0x1234, rs2_busy=0; without the macro: old data, busy=1, then new data and busy=0 the next cycle.
- Saturation (CNT_WIDTH=2): reserve x3 three times -> issue_ready=0 for rd=3; add a writeback to x3 in the same cycle -> issue_ready=1 and the reserve is accepted, cnt stays 3.
- x0 and regW=0: writeback {0xFFFFFFFF, 0, 1} and {0xAA, 4, 0} -> x0 reads 0, x4 unchanged, counters unchanged, wb_err=0.
- Underflow: writeback {0x55, 9, 1} with cnt[9]=0 -> reg[9]=0x55, cnt[9]=0, wb_err=1 and held until the next reset.
